// File: rtl/regfile_reader_if.sv
// Bundle between the write-back stage, the decode stage and the register file.
// master: the pipeline side that drives writes and read requests.
// slave:  the register file that returns the registered operands.
interface regfile_reader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wb_reg_wen;
   logic [ADDR_W-1:0] wb_reg_waddr;
   logic [DATA_W-1:0] wb_reg_wdata;

   logic              id_rs1_rd;
   logic [ADDR_W-1:0] id_rs1_addr;
   logic              id_rs2_rd;
   logic [ADDR_W-1:0] id_rs2_addr;
   logic              id_stall;
   logic              id_flush;

   logic [DATA_W-1:0] rs1_rdata;
   logic [DATA_W-1:0] rs2_rdata;

   modport master (
      output wb_reg_wen, wb_reg_waddr, wb_reg_wdata,
      output id_rs1_rd, id_rs1_addr, id_rs2_rd, id_rs2_addr,
      output id_stall, id_flush,
      input  rs1_rdata, rs2_rdata
   );

   modport slave (
      input  wb_reg_wen, wb_reg_waddr, wb_reg_wdata,
      input  id_rs1_rd, id_rs1_addr, id_rs2_rd, id_rs2_addr,
      input  id_stall, id_flush,
      output rs1_rdata, rs2_rdata
   );
endinterface

// File: rtl/regfile_reader.sv
// Integer register file with two registered read ports feeding the ID/EX
// boundary. A read that coincides with a WB write to the same register sees
// the new value, and a stalled port keeps following WB writes to the register
// it is holding, so decode never consumes a stale operand. x0 reads as zero.
module regfile_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   regfile_reader_if.slave  rf
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } port_t;

   logic [DATA_W-1:0] mem_q [DEPTH];

   port_t rs1_q, rs1_d;
   port_t rs2_q, rs2_d;

   logic              wr_en;
   logic [DATA_W-1:0] rs1_arr;
   logic [DATA_W-1:0] rs2_arr;

   // x0 writes are dropped here, so entry 0 never leaves its reset value
   assign wr_en   = rf.wb_reg_wen && (rf.wb_reg_waddr != '0);
   assign rs1_arr = mem_q[rf.id_rs1_addr];
   assign rs2_arr = mem_q[rf.id_rs2_addr];

   // Next operand state for one port: flush, then stall refresh, then a fresh
   // read with same-cycle bypass, otherwise hold.
   function automatic port_t port_next(
      input port_t             cur,
      input logic              rd,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] arr_data,
      input logic              flush,
      input logic              stall,
      input logic              wen,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      port_t nxt;
      nxt = cur;
      if (flush) begin
         nxt.addr = '0;
         nxt.data = '0;
      end else if (stall) begin
         if (wen && (waddr == cur.addr) && (cur.addr != '0)) begin
            nxt.data = wdata;
         end
      end else if (rd) begin
         nxt.addr = addr;
         if (addr == '0) begin
            nxt.data = '0;
         end else if (wen && (waddr == addr)) begin
            nxt.data = wdata;
         end else begin
            nxt.data = arr_data;
         end
      end
      return nxt;
   endfunction

   // Operand next-state for both ports; the ports are fully independent
   always_comb begin
      rs1_d = port_next(rs1_q, rf.id_rs1_rd, rf.id_rs1_addr, rs1_arr,
                        rf.id_flush, rf.id_stall,
                        rf.wb_reg_wen, rf.wb_reg_waddr, rf.wb_reg_wdata);
      rs2_d = port_next(rs2_q, rf.id_rs2_rd, rf.id_rs2_addr, rs2_arr,
                        rf.id_flush, rf.id_stall,
                        rf.wb_reg_wen, rf.wb_reg_waddr, rf.wb_reg_wdata);
   end

   // Register array; the write lands regardless of stall or flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[rf.wb_reg_waddr] <= rf.wb_reg_wdata;
      end
   end

   // Latched read addresses and registered operands
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs1_q <= '0;
         rs2_q <= '0;
      end else begin
         rs1_q <= rs1_d;
         rs2_q <= rs2_d;
      end
   end

   assign rf.rs1_rdata = rs1_q.data;
   assign rf.rs2_rdata = rs2_q.data;

endmodule
